// File: rtl/bconv_engine.sv
// Binary convolution engine: streams images from the input SRAM, slides a KxK
// XNOR-popcount window over each and writes one thresholded word per output row.
module bconv_engine #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned MAX_K  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dut_run,
  output logic              dut_busy,
  output logic              dut_err,
  output logic [ADDR_W-1:0] dut_wmem_read_address,
  input  logic [DATA_W-1:0] wmem_dut_read_data,
  output logic [ADDR_W-1:0] dut_sram_read_address,
  input  logic [DATA_W-1:0] sram_dut_read_data,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [DATA_W-1:0] dut_sram_write_data,
  output logic              dut_sram_write_enable
);

  localparam int unsigned KW  = $clog2(MAX_K + 1);
  localparam int unsigned KK  = MAX_K * MAX_K;
  localparam int unsigned CW  = $clog2(KK + 1);
  localparam int unsigned CLW = $clog2(DATA_W);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LD_K   = 4'd1;
  localparam logic [3:0] S_LD_W   = 4'd2;
  localparam logic [3:0] S_LD_HDR = 4'd3;
  localparam logic [3:0] S_FILL   = 4'd4;
  localparam logic [3:0] S_CONV   = 4'd5;
  localparam logic [3:0] S_WRITE  = 4'd6;
  localparam logic [3:0] S_SHIFT  = 4'd7;
  localparam logic [3:0] S_SKIP   = 4'd8;
  localparam logic [3:0] S_DONE   = 4'd9;

  logic [3:0]        state;
  logic              w_iss, w_vld, s_iss, s_vld;
  logic [KW-1:0]     k_r;
  logic [DATA_W-1:0] nrows_r, ncols_r, rows_loaded, iss_left, rcv_cnt, conv_cnt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] win    [MAX_K];
  logic [MAX_K-1:0]  wgt    [MAX_K];
  logic [DATA_W-1:0] win_sh [MAX_K];
  logic [MAX_K-1:0]  wgt_sh [MAX_K];
  logic              p1_v, p2_v, p2_res;
  logic [CLW-1:0]    p1_col, p2_col;
  logic [KK-1:0]     p1_match, match_c;
  logic [CW-1:0]     m_c;
  logic [CW:0]       k_sq;
  logic [DATA_W-1:0] lim, row_sh;
  logic              more, conv_issue, k_bad;
  int unsigned       k_int;

  assign dut_sram_write_enable = (state == S_WRITE);
  assign dut_sram_write_data   = (state == S_WRITE) ? acc : '0;

  always_comb begin
    k_int      = 32'(k_r);
    k_sq       = (CW+1)'(k_r) * (CW+1)'(k_r);
    lim        = ncols_r - DATA_W'(k_r);
    more       = (rows_loaded < nrows_r);
    conv_issue = (state == S_CONV) && (conv_cnt <= lim);
    k_bad      = (wmem_dut_read_data == '0) || !wmem_dut_read_data[0] ||
                 (wmem_dut_read_data > DATA_W'(MAX_K));
    // New rows/weights enter at row K-1 so row 0 is always the oldest one.
    for (int unsigned i = 0; i + 1 < MAX_K; i++) begin
      win_sh[i] = win[i+1];
      wgt_sh[i] = wgt[i+1];
    end
    win_sh[MAX_K-1] = '0;
    wgt_sh[MAX_K-1] = '0;
    win_sh[k_r - KW'(1)] = sram_dut_read_data;
    wgt_sh[k_r - KW'(1)] = wmem_dut_read_data[MAX_K-1:0];
    match_c = '0;
    row_sh  = '0;
    for (int unsigned i = 0; i < MAX_K; i++) begin
      row_sh = win[i] >> conv_cnt;
      for (int unsigned j = 0; j < MAX_K; j++)
        if (i < k_int && j < k_int)
          match_c[i*MAX_K+j] = ~(row_sh[j] ^ wgt[i][j]);
    end
    m_c = '0;
    for (int unsigned n = 0; n < KK; n++)
      m_c = m_c + CW'(p1_match[n]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                  <= S_IDLE;
      dut_busy               <= 1'b0;
      dut_err                <= 1'b0;
      dut_wmem_read_address  <= '0;
      dut_sram_read_address  <= '0;
      dut_sram_write_address <= '0;
      {w_iss, w_vld, s_iss, s_vld} <= '0;
      k_r         <= '0;
      nrows_r     <= '0;
      ncols_r     <= '0;
      rows_loaded <= '0;
      iss_left    <= '0;
      rcv_cnt     <= '0;
      conv_cnt    <= '0;
      acc         <= '0;
      {p1_v, p2_v, p2_res} <= '0;
      p1_col      <= '0;
      p2_col      <= '0;
      p1_match    <= '0;
      for (int unsigned i = 0; i < MAX_K; i++) begin
        win[i] <= '0;
        wgt[i] <= '0;
      end
    end else begin
      // Read address always points at the next unread word; each issue advances it.
      w_vld <= w_iss;
      s_vld <= s_iss;
      if (w_iss) dut_wmem_read_address <= dut_wmem_read_address + ADDR_W'(1);
      if (s_iss) dut_sram_read_address <= dut_sram_read_address + ADDR_W'(1);
      w_iss <= 1'b0;
      s_iss <= 1'b0;
      p1_v     <= conv_issue;
      p1_col   <= conv_cnt[CLW-1:0];
      p1_match <= match_c;
      p2_v     <= p1_v;
      p2_col   <= p1_col;
      p2_res   <= ({m_c, 1'b0} >= k_sq);
      if (p2_v && p2_res) acc <= acc | (DATA_W'(1) << p2_col);
      case (state)
        S_IDLE: if (dut_run) begin
          dut_busy               <= 1'b1;
          dut_err                <= 1'b0;
          dut_wmem_read_address  <= '0;
          dut_sram_read_address  <= '0;
          dut_sram_write_address <= '0;
          w_iss                  <= 1'b1;
          state                  <= S_LD_K;
        end
        S_LD_K: if (w_vld) begin
          if (k_bad) begin
            dut_err <= 1'b1;
            state   <= S_DONE;
          end else begin
            k_r      <= KW'(wmem_dut_read_data);
            w_iss    <= 1'b1;
            iss_left <= wmem_dut_read_data - DATA_W'(1);
            rcv_cnt  <= '0;
            state    <= S_LD_W;
          end
        end
        S_LD_W: begin
          if (iss_left != '0) begin
            w_iss    <= 1'b1;
            iss_left <= iss_left - DATA_W'(1);
          end
          if (w_vld) begin
            wgt     <= wgt_sh;
            rcv_cnt <= rcv_cnt + DATA_W'(1);
            if (rcv_cnt == DATA_W'(k_r) - DATA_W'(1)) begin
              s_iss    <= 1'b1;
              iss_left <= DATA_W'(1);
              rcv_cnt  <= '0;
              state    <= S_LD_HDR;
            end
          end
        end
        S_LD_HDR: begin
          if (iss_left != '0) begin
            s_iss    <= 1'b1;
            iss_left <= iss_left - DATA_W'(1);
          end
          if (s_vld) begin
            rcv_cnt <= rcv_cnt + DATA_W'(1);
            if (rcv_cnt == '0) begin
              nrows_r <= sram_dut_read_data;
              if (sram_dut_read_data == '1) state <= S_DONE;
            end else begin
              ncols_r <= sram_dut_read_data;
              if (sram_dut_read_data > DATA_W'(DATA_W)) begin
                dut_err <= 1'b1;
                state   <= S_DONE;
              end else if (DATA_W'(k_r) > nrows_r || DATA_W'(k_r) > sram_dut_read_data) begin
                state <= S_SKIP;
              end else begin
                s_iss       <= 1'b1;
                iss_left    <= DATA_W'(k_r) - DATA_W'(1);
                rcv_cnt     <= '0;
                rows_loaded <= DATA_W'(k_r);
                state       <= S_FILL;
              end
            end
          end
        end
        S_SKIP: begin
          dut_sram_read_address <= dut_sram_read_address + ADDR_W'(nrows_r);
          s_iss    <= 1'b1;
          iss_left <= DATA_W'(1);
          rcv_cnt  <= '0;
          state    <= S_LD_HDR;
        end
        S_FILL: begin
          if (iss_left != '0) begin
            s_iss    <= 1'b1;
            iss_left <= iss_left - DATA_W'(1);
          end
          if (s_vld) begin
            win     <= win_sh;
            rcv_cnt <= rcv_cnt + DATA_W'(1);
            if (rcv_cnt == DATA_W'(k_r) - DATA_W'(1)) begin
              conv_cnt <= '0;
              state    <= S_CONV;
            end
          end
        end
        S_CONV: begin
          conv_cnt <= conv_cnt + DATA_W'(1);
          if (conv_cnt == lim + DATA_W'(2)) state <= S_WRITE;
        end
        S_WRITE: begin
          acc                    <= '0;
          dut_sram_write_address <= dut_sram_write_address + ADDR_W'(1);
          if (more) s_iss <= 1'b1;
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (!more) begin
            s_iss    <= 1'b1;
            iss_left <= DATA_W'(1);
            rcv_cnt  <= '0;
            state    <= S_LD_HDR;
          end else if (s_vld) begin
            win         <= win_sh;
            rows_loaded <= rows_loaded + DATA_W'(1);
            conv_cnt    <= '0;
            state       <= S_CONV;
          end
        end
        S_DONE: begin
          dut_busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bconv_engine.sv
// Directed bench for bconv_engine: synchronous memory models, a write logger
// and one task per scenario with hand-computed expected output words.
module tb_bconv_engine;
  localparam int DW = 16;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset, dut_run;
  logic          dut_busy, dut_err, dut_sram_write_enable;
  logic [AW-1:0] dut_wmem_read_address, dut_sram_read_address, dut_sram_write_address;
  logic [DW-1:0] wmem_dut_read_data, sram_dut_read_data, dut_sram_write_data;

  bconv_engine #(.DATA_W(DW), .ADDR_W(AW), .MAX_K(5)) dut (
    .clk(clk), .reset(reset), .dut_run(dut_run), .dut_busy(dut_busy), .dut_err(dut_err),
    .dut_wmem_read_address(dut_wmem_read_address), .wmem_dut_read_data(wmem_dut_read_data),
    .dut_sram_read_address(dut_sram_read_address), .sram_dut_read_data(sram_dut_read_data),
    .dut_sram_write_address(dut_sram_write_address), .dut_sram_write_data(dut_sram_write_data),
    .dut_sram_write_enable(dut_sram_write_enable));

  always #5 clk = ~clk;

  logic [DW-1:0] wmem [4096];
  logic [DW-1:0] sram [4096];
  always @(posedge clk) begin
    wmem_dut_read_data <= wmem[dut_wmem_read_address];
    sram_dut_read_data <= sram[dut_sram_read_address];
  end

  int total = 0;
  int bad = 0;
  int wr_count = 0;
  logic [AW-1:0] log_addr [256];
  logic [DW-1:0] log_data [256];
  always @(negedge clk) if (dut_sram_write_enable === 1'b1) begin
    if (wr_count < 256) begin
      log_addr[wr_count] = dut_sram_write_address;
      log_data[wr_count] = dut_sram_write_data;
    end
    wr_count = wr_count + 1;
  end

  int ptr;
  task automatic clear_mem;
    for (int i = 0; i < 4096; i++) begin sram[i] = '0; wmem[i] = '0; end
    ptr = 0;
  endtask
  task automatic put(input logic [DW-1:0] w);
    sram[ptr] = w;
    ptr = ptr + 1;
  endtask
  task automatic set_w(input logic [DW-1:0] k, r0, r1, r2, r3, r4);
    wmem[0] = k; wmem[1] = r0; wmem[2] = r1; wmem[3] = r2; wmem[4] = r3; wmem[5] = r4;
  endtask
  task automatic load_square(input int n, input logic [DW-1:0] row);
    put(DW'(n)); put(DW'(n));
    for (int i = 0; i < n; i++) put(row);
  endtask

  task automatic run_job(output bit started, output bit timed_out, output int base);
    base = wr_count;
    @(negedge clk) dut_run = 1'b1;
    @(negedge clk) dut_run = 1'b0;
    started = dut_busy;
    timed_out = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (dut_busy === 1'b0) begin timed_out = 1'b0; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; dut_run = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (dut_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", dut_busy); end
    total++; if (dut_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", dut_err); end
    total++; if (dut_sram_write_enable !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", dut_sram_write_enable); end
    total++; if (dut_sram_write_data !== '0) begin bad++; $display("FAIL reset_wdata: got %h want 0", dut_sram_write_data); end
    total++; if ({dut_wmem_read_address, dut_sram_read_address, dut_sram_write_address} !== '0) begin
      bad++; $display("FAIL reset_addr: got %h/%h/%h want 0/0/0", dut_wmem_read_address, dut_sram_read_address, dut_sram_write_address);
    end
    reset = 1'b0;
    @(negedge clk);
    total++; if (dut_busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", dut_busy); end
  endtask

  task automatic test_ones;
    bit st, to; int base;
    clear_mem();
    set_w(3, 16'h7, 16'h7, 16'h7, 0, 0);
    load_square(16, 16'hFFFF);
    put(16'hFFFF);
    run_job(st, to, base);
    total++; if (st !== 1'b1) begin bad++; $display("FAIL ones_start: busy=%b want 1", st); end
    total++; if (to) begin bad++; $display("FAIL ones_timeout: busy still %b want 0", dut_busy); end
    total++; if (wr_count - base != 14) begin bad++; $display("FAIL ones_count: got %0d want 14", wr_count - base); end
    for (int i = 0; i < 14; i++) begin
      total++;
      if (log_addr[base+i] !== AW'(i) || log_data[base+i] !== 16'h3FFF) begin
        bad++; $display("FAIL ones_word[%0d]: got addr=%0d data=%h want addr=%0d data=3fff", i, log_addr[base+i], log_data[base+i], i);
      end
    end
    total++; if (dut_err !== 1'b0) begin bad++; $display("FAIL ones_err: got %b want 0", dut_err); end
  endtask

  task automatic test_zero_input;
    bit st, to; int base;
    logic [DW-1:0] wrow, want;
    for (int pass = 0; pass < 2; pass++) begin
      wrow = (pass == 0) ? 16'h7 : 16'h0;
      want = (pass == 0) ? 16'h0000 : 16'h3FFF;
      clear_mem();
      set_w(3, wrow, wrow, wrow, 0, 0);
      load_square(16, 16'h0000);
      put(16'hFFFF);
      run_job(st, to, base);
      total++; if (to || wr_count - base != 14) begin
        bad++; $display("FAIL zero_count[%0d]: got %0d writes timeout=%b want 14 timeout=0", pass, wr_count - base, to);
      end
      for (int i = 0; i < 14; i++) begin
        total++;
        if (log_addr[base+i] !== AW'(i) || log_data[base+i] !== want) begin
          bad++; $display("FAIL zero_word[%0d][%0d]: got addr=%0d data=%h want addr=%0d data=%h", pass, i, log_addr[base+i], log_data[base+i], i, want);
        end
      end
    end
  endtask

  task automatic test_checker;
    bit st, to; int base;
    logic [DW-1:0] exp_w [4];
    exp_w = '{16'h05, 16'h0A, 16'h05, 16'h0A};
    clear_mem();
    set_w(5, 16'h15, 16'h0A, 16'h15, 16'h0A, 16'h15);
    put(8); put(8);
    for (int r = 0; r < 8; r++) put((r % 2 == 0) ? 16'h55 : 16'hAA);
    put(16'hFFFF);
    run_job(st, to, base);
    total++; if (to || wr_count - base != 4) begin
      bad++; $display("FAIL chk_count: got %0d writes timeout=%b want 4 timeout=0", wr_count - base, to);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (log_addr[base+i] !== AW'(i) || log_data[base+i] !== exp_w[i]) begin
        bad++; $display("FAIL chk_word[%0d]: got addr=%0d data=%h want addr=%0d data=%h", i, log_addr[base+i], log_data[base+i], i, exp_w[i]);
      end
    end
  endtask

  task automatic load_two_images(input bit with_skip);
    clear_mem();
    set_w(3, 16'h7, 16'h7, 16'h7, 0, 0);
    load_square(3, 16'h7);
    if (with_skip) load_square(2, 16'h3);
    put(4); put(4); put(16'hF); put(16'h7); put(16'h1); put(16'h8);
    put(16'hFFFF);
  endtask

  task automatic test_two_images;
    bit st, to; int base;
    logic [DW-1:0] exp_w [3];
    exp_w = '{16'h1, 16'h3, 16'h0};
    for (int pass = 0; pass < 2; pass++) begin
      load_two_images(pass == 1);
      run_job(st, to, base);
      total++; if (to || wr_count - base != 3) begin
        bad++; $display("FAIL two_count[%0d]: got %0d writes timeout=%b want 3 timeout=0", pass, wr_count - base, to);
      end
      for (int i = 0; i < 3; i++) begin
        total++;
        if (log_addr[base+i] !== AW'(i) || log_data[base+i] !== exp_w[i]) begin
          bad++; $display("FAIL two_word[%0d][%0d]: got addr=%0d data=%h want addr=%0d data=%h", pass, i, log_addr[base+i], log_data[base+i], i, exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_errors;
    bit st, to; int base;
    logic [DW-1:0] bad_k [3];
    bad_k = '{16'd4, 16'd0, 16'd7};
    for (int n = 0; n < 4; n++) begin
      clear_mem();
      if (n < 3) begin
        set_w(bad_k[n], 16'h1F, 16'h1F, 16'h1F, 16'h1F, 16'h1F);
        load_square(3, 16'h7);
      end else begin
        set_w(3, 16'h7, 16'h7, 16'h7, 0, 0);
        put(4); put(17); put(16'hFFFF); put(16'hFFFF); put(16'hFFFF); put(16'hFFFF);
      end
      put(16'hFFFF);
      run_job(st, to, base);
      total++; if (to || dut_err !== 1'b1) begin
        bad++; $display("FAIL err_flag[%0d]: got err=%b timeout=%b want err=1 timeout=0", n, dut_err, to);
      end
      total++; if (wr_count != base) begin bad++; $display("FAIL err_writes[%0d]: got %0d want 0", n, wr_count - base); end
    end
    load_two_images(1'b0);
    run_job(st, to, base);
    total++; if (to || dut_err !== 1'b0) begin
      bad++; $display("FAIL err_clear: got err=%b timeout=%b want err=0 timeout=0", dut_err, to);
    end
    total++; if (wr_count - base != 3) begin bad++; $display("FAIL err_recover: got %0d writes want 3", wr_count - base); end
  endtask

  task automatic test_reset_mid;
    bit st, to, seen; int base, b0, at_reset;
    clear_mem();
    set_w(3, 16'h7, 16'h7, 16'h7, 0, 0);
    load_square(16, 16'hFFFF);
    put(16'hFFFF);
    b0 = wr_count;
    @(negedge clk) dut_run = 1'b1;
    @(negedge clk) dut_run = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (wr_count > b0) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    total++; if (!seen) begin bad++; $display("FAIL mid_first_write: got none want 1"); end
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    total++; if (dut_sram_write_enable !== 1'b0 || dut_busy !== 1'b0) begin
      bad++; $display("FAIL mid_reset_ctl: got we=%b busy=%b want 0/0", dut_sram_write_enable, dut_busy);
    end
    total++; if ({dut_wmem_read_address, dut_sram_read_address, dut_sram_write_address, dut_sram_write_data} !== '0) begin
      bad++; $display("FAIL mid_reset_out: got %h/%h/%h/%h want all 0", dut_wmem_read_address, dut_sram_read_address, dut_sram_write_address, dut_sram_write_data);
    end
    at_reset = wr_count;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    total++; if (wr_count != at_reset) begin bad++; $display("FAIL mid_no_write: got %0d extra want 0", wr_count - at_reset); end
    run_job(st, to, base);
    total++; if (to || wr_count - base != 14) begin
      bad++; $display("FAIL mid_rerun_count: got %0d timeout=%b want 14 timeout=0", wr_count - base, to);
    end
    total++; if (log_addr[base] !== '0 || log_data[base] !== 16'h3FFF) begin
      bad++; $display("FAIL mid_rerun_first: got addr=%0d data=%h want addr=0 data=3fff", log_addr[base], log_data[base]);
    end
    total++; if (log_addr[base+13] !== AW'(13)) begin
      bad++; $display("FAIL mid_rerun_last: got addr=%0d want 13", log_addr[base+13]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear_mem();
    test_reset();
    test_ones();
    test_zero_input();
    test_checker();
    test_two_images();
    test_errors();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
